// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU issue/capture controller with a four-entry register file
module alu_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [3:0]   instr_op,
    input  logic [1:0]   instr_dst,
    input  logic [1:0]   instr_src,
    input  logic [N-1:0] instr_imm,
    output logic         alu_enable,
    output logic [2:0]   alu_mode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    input  logic         alu_zero,
    input  logic         alu_carry,
    output logic         done,
    output logic         flag_z,
    output logic         flag_c,
    input  logic [1:0]   dbg_sel,
    output logic [N-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOADI = 4'b1000;
    localparam logic [3:0] OP_MOV   = 4'b1001;
    localparam logic [2:0] MODE_CMP = 3'b111;

    state_t       state_q, state_d;
    logic [N-1:0] rf_q [4];
    logic [N-1:0] rf_d [4];
    logic [1:0]   dst_q, dst_d;
    logic [2:0]   mode_q, mode_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         done_q, done_d;
    logic         fz_q, fz_d;
    logic         fc_q, fc_d;

    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        dst_d   = dst_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        fz_d    = fz_q;
        fc_d    = fc_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (!instr_op[3]) begin
                        // Operands are read before any write, so dst==src sees the old value.
                        state_d = S_ISSUE;
                        dst_d   = instr_dst;
                        mode_d  = instr_op[2:0];
                        a_d     = rf_q[instr_dst];
                        b_d     = rf_q[instr_src];
                    end else begin
                        done_d = 1'b1;
                        if (instr_op == OP_LOADI) begin
                            rf_d[instr_dst] = instr_imm;
                        end else if (instr_op == OP_MOV) begin
                            rf_d[instr_dst] = rf_q[instr_src];
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                fz_d = alu_zero;
                fc_d = alu_carry;
                if (mode_q != MODE_CMP) begin
                    rf_d[dst_q] = alu_out;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            dst_q  <= '0;
            mode_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            done_q <= 1'b0;
            fz_q   <= 1'b0;
            fc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
            dst_q  <= dst_d;
            mode_q <= mode_d;
            a_q    <= a_d;
            b_q    <= b_d;
            done_q <= done_d;
            fz_q   <= fz_d;
            fc_q   <= fc_d;
        end
    end

    // Decoded from state so that an asynchronous reset drops the enable immediately.
    assign alu_enable  = (state_q == S_ISSUE);
    assign instr_ready = (state_q == S_IDLE);
    assign alu_mode    = mode_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign done        = done_q;
    assign flag_z      = fz_q;
    assign flag_c      = fc_q;
    assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and register model
module tb_alu_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         instr_valid;
    logic         instr_ready;
    logic [3:0]   instr_op;
    logic [1:0]   instr_dst;
    logic [1:0]   instr_src;
    logic [N-1:0] instr_imm;
    logic         alu_enable;
    logic [2:0]   alu_mode;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_out;
    logic         alu_zero;
    logic         alu_carry;
    logic         done;
    logic         flag_z;
    logic         flag_c;
    logic [1:0]   dbg_sel;
    logic [N-1:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_rf [4];
    logic       m_z;
    logic       m_c;

    alu_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_src(instr_src), .instr_imm(instr_imm),
        .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .done(done), .flag_z(flag_z), .flag_c(flag_c),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each ALU mode; returns {zero, carry, result}.
    function automatic logic [9:0] alu_ref(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        logic [7:0] r;
        logic c;
        case (m)
            3'd0: begin r = 8'(ai + bi); c = (ai + bi) > 255; end
            3'd1: begin r = 8'(ai - bi); c = ai < bi; end
            3'd2: begin r = 8'(ai + 1);  c = (ai == 255); end
            3'd3: begin r = 8'(ai - 1);  c = (ai == 0); end
            3'd4: begin r = a & b; c = 1'b0; end
            3'd5: begin r = a | b; c = 1'b0; end
            3'd6: begin r = a ^ b; c = 1'b0; end
            default: begin r = 8'(ai - bi); c = ai < bi; end
        endcase
        return {(r == 8'h00), c, r};
    endfunction

    // External ALU: samples on the enabled edge, result registered.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {alu_zero, alu_carry, alu_out} <= '0;
        end else if (alu_enable) begin
            {alu_zero, alu_carry, alu_out} <= alu_ref(alu_mode, alu_a, alu_b);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] imm);
        logic [9:0] res;
        if (!op[3]) begin
            res = alu_ref(op[2:0], m_rf[d], m_rf[s]);
            m_z = res[9];
            m_c = res[8];
            if (op[2:0] != 3'b111) m_rf[d] = res[7:0];
        end else if (op == 4'b1000) begin
            m_rf[d] = imm;
        end else if (op == 4'b1001) begin
            m_rf[d] = m_rf[s];
        end
    endtask

    // Starts and ends on a falling edge; lat is the falling-edge count until done (0 = timeout).
    task automatic exec(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] imm,
                        output int lat, output int en_cnt, output int rdy_low, output logic done_after,
                        output logic [2:0] mode_seen, output logic [7:0] a_seen, output logic [7:0] b_seen);
        lat = 0; en_cnt = 0; rdy_low = 0;
        mode_seen = 3'bx; a_seen = 8'hxx; b_seen = 8'hxx;
        instr_op = op; instr_dst = d; instr_src = s; instr_imm = imm;
        instr_valid = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) instr_valid = 1'b0;
            if (alu_enable) begin
                en_cnt++;
                mode_seen = alu_mode; a_seen = alu_a; b_seen = alu_b;
            end
            if (!instr_ready) rdy_low++;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            tests++;
            if (dbg_data !== 8'h00) begin
                fails++;
                $display("FAIL reset_r%0d: got %h expected 00", i, dbg_data);
            end
        end
        tests++;
        if ({instr_ready, done, flag_z, flag_c, alu_enable} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: ready/done/z/c/en got %b expected 10000",
                     {instr_ready, done, flag_z, flag_c, alu_enable});
        end
        tests++;
        if ({alu_mode, alu_a, alu_b} !== 19'h0) begin
            fails++;
            $display("FAIL reset_alu_bus: got mode=%h a=%h b=%h expected zeros", alu_mode, alu_a, alu_b);
        end
    endtask

    task automatic test_loadi_back_to_back();
        instr_op = 4'b1000; instr_dst = 2'd0; instr_src = 2'd0; instr_imm = 8'hF0;
        instr_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL loadi_first_done: done=%b ready=%b expected 1 1", done, instr_ready);
        end
        instr_dst = 2'd1; instr_imm = 8'h20;
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL loadi_second_done: got %b expected 1", done);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL loadi_done_drop: got %b expected 0", done);
        end
        model_apply(4'b1000, 2'd0, 2'd0, 8'hF0);
        model_apply(4'b1000, 2'd1, 2'd0, 8'h20);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            tests++;
            if (dbg_data !== m_rf[i]) begin
                fails++;
                $display("FAIL loadi_r%0d: got %h expected %h", i, dbg_data, m_rf[i]);
            end
        end
    endtask

    task automatic test_add();
        int lat, en, rl;
        logic da;
        logic [2:0] ms;
        logic [7:0] as, bs;
        exec(4'b0000, 2'd0, 2'd1, 8'h00, lat, en, rl, da, ms, as, bs);
        model_apply(4'b0000, 2'd0, 2'd1, 8'h00);
        tests++;
        if (en !== 1 || ms !== 3'b000 || as !== 8'hF0 || bs !== 8'h20) begin
            fails++;
            $display("FAIL add_issue: en_cycles=%0d mode=%h a=%h b=%h expected 1 0 f0 20", en, ms, as, bs);
        end
        tests++;
        if (rl !== 2 || lat !== 3 || da !== 1'b0) begin
            fails++;
            $display("FAIL add_timing: ready_low=%0d done_at=%0d done_after=%b expected 2 3 0", rl, lat, da);
        end
        dbg_sel = 2'd0;
        #1;
        tests++;
        if (dbg_data !== 8'h10 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            fails++;
            $display("FAIL add_result: r0=%h c=%b z=%b expected 10 1 0", dbg_data, flag_c, flag_z);
        end
    endtask

    task automatic test_cmp();
        int lat, en, rl;
        logic da;
        logic [2:0] ms;
        logic [7:0] as, bs;
        exec(4'b0111, 2'd1, 2'd1, 8'h00, lat, en, rl, da, ms, as, bs);
        model_apply(4'b0111, 2'd1, 2'd1, 8'h00);
        dbg_sel = 2'd1;
        #1;
        tests++;
        if (dbg_data !== 8'h20 || flag_z !== 1'b1 || flag_c !== 1'b0 || lat !== 3) begin
            fails++;
            $display("FAIL cmp: r1=%h z=%b c=%b done_at=%0d expected 20 1 0 3", dbg_data, flag_z, flag_c, lat);
        end
    endtask

    task automatic test_inc_mov();
        int lat, en, rl;
        logic da;
        logic [2:0] ms;
        logic [7:0] as, bs;
        exec(4'b1000, 2'd2, 2'd0, 8'hFF, lat, en, rl, da, ms, as, bs);
        model_apply(4'b1000, 2'd2, 2'd0, 8'hFF);
        exec(4'b0010, 2'd2, 2'd3, 8'h00, lat, en, rl, da, ms, as, bs);
        model_apply(4'b0010, 2'd2, 2'd3, 8'h00);
        dbg_sel = 2'd2;
        #1;
        tests++;
        if (dbg_data !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            fails++;
            $display("FAIL inc_wrap: r2=%h c=%b z=%b expected 00 1 1", dbg_data, flag_c, flag_z);
        end
        exec(4'b1000, 2'd3, 2'd0, 8'h5A, lat, en, rl, da, ms, as, bs);
        model_apply(4'b1000, 2'd3, 2'd0, 8'h5A);
        exec(4'b1001, 2'd3, 2'd2, 8'h00, lat, en, rl, da, ms, as, bs);
        model_apply(4'b1001, 2'd3, 2'd2, 8'h00);
        dbg_sel = 2'd3;
        #1;
        tests++;
        if (dbg_data !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1 || lat !== 1) begin
            fails++;
            $display("FAIL mov: r3=%h c=%b z=%b done_at=%0d expected 00 1 1 1", dbg_data, flag_c, flag_z, lat);
        end
    endtask

    task automatic test_random();
        int lat, en, rl;
        logic da;
        logic [2:0] ms;
        logic [7:0] as, bs;
        logic [3:0] op;
        logic [1:0] d, s;
        logic [7:0] imm;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            d = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            imm = 8'($urandom);
            exec(op, d, s, imm, lat, en, rl, da, ms, as, bs);
            tests++;
            if (!op[3]) begin
                if (lat !== 3 || en !== 1 || ms !== op[2:0] || as !== m_rf[d] || bs !== m_rf[s]) begin
                    fails++;
                    $display("FAIL rand_alu_issue[%0d]: op=%h done_at=%0d en=%0d mode=%h a=%h b=%h expected 3 1 %h %h %h",
                             n, op, lat, en, ms, as, bs, op[2:0], m_rf[d], m_rf[s]);
                end
            end else if (lat !== 1 || en !== 0) begin
                fails++;
                $display("FAIL rand_simple_timing[%0d]: op=%h done_at=%0d en=%0d expected 1 0", n, op, lat, en);
            end
            model_apply(op, d, s, imm);
            tests++;
            if (flag_z !== m_z || flag_c !== m_c || da !== 1'b0) begin
                fails++;
                $display("FAIL rand_flags[%0d]: z=%b c=%b done_after=%b expected %b %b 0", n, flag_z, flag_c, da, m_z, m_c);
            end
            for (int i = 0; i < 4; i++) begin
                dbg_sel = 2'(i);
                #1;
                tests++;
                if (dbg_data !== m_rf[i]) begin
                    fails++;
                    $display("FAIL rand_r%0d[%0d]: got %h expected %h", i, n, dbg_data, m_rf[i]);
                end
            end
        end
    endtask

    // capture_phase=0 hits ISSUE, 1 hits CAPTURE.
    task automatic test_reset_midop(input int capture_phase);
        int lat, en, rl;
        logic da;
        logic [2:0] ms;
        logic [7:0] as, bs;
        logic done_seen;
        exec(4'b1000, 2'd1, 2'd0, 8'h33, lat, en, rl, da, ms, as, bs);
        instr_op = 4'b0000; instr_dst = 2'd1; instr_src = 2'd1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        if (capture_phase == 1) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (alu_enable !== 1'b0 || instr_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop%0d_async: en=%b ready=%b done=%b expected 0 1 0",
                     capture_phase, alu_enable, instr_ready, done);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        tests++;
        if (done_seen !== 1'b0 || instr_ready !== 1'b1 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop%0d_after: done_seen=%b ready=%b z=%b c=%b expected 0 1 0 0",
                     capture_phase, done_seen, instr_ready, flag_z, flag_c);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            tests++;
            if (dbg_data !== 8'h00) begin
                fails++;
                $display("FAIL reset_midop%0d_r%0d: got %h expected 00", capture_phase, i, dbg_data);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr_op = 4'h0; instr_dst = 2'd0; instr_src = 2'd0; instr_imm = 8'h00;
        dbg_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_loadi_back_to_back();
        test_add();
        test_cmp();
        test_inc_mov();
        test_random();
        test_reset_midop(0);
        test_reset_midop(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
